dmem_responder: RTL
===================

# dmem_responder

Synchronous data-memory responder on the far side of the core's dmem port. Accepts the core's active-low chip-select read and write requests, applies byte-masked writes to an internal word array, and returns read data after a fixed, parameterized latency. It replaces the external SRAM macro in simulation and FPGA builds. It also exposes a read-valid strobe and saturating access counters for verification.

## Interface
- ADDR_W, 8, word-address width; array depth is 2^ADDR_W words
- DATA_W, 32, word width; must be a multiple of 8
- READ_LATENCY, 1, edges from read sample to `dmem_dout_o` update; legal values 1..3
- CNT_W, 16, width of the access counters

- clk_i  input  1  single clock; all state is updated on the rising edge
- reset_i  input  1  asynchronous, active-low reset
- dmem_csb_write_i  input  1  active-low write select
- dmem_wmask_i  input  DATA_W/8  byte enables; bit b covers data bits [8b+7:8b]
- dmem_waddr_i  input  ADDR_W  write word address
- dmem_din_i  input  DATA_W  write data
- dmem_csb_read_i  input  1  active-low read select
- dmem_raddr_i  input  ADDR_W  read word address
- dmem_dout_o  output  DATA_W  read data; holds its value between reads
- rd_valid_o  output  1  one-cycle pulse; coincides with each `dmem_dout_o` update
- wr_count_o  output  CNT_W  number of accepted writes, saturating
- rd_count_o  output  CNT_W  number of accepted reads, saturating

## Operation
- **Write.** Accepted on a rising edge where `dmem_csb_write_i`=0. For each b with `wmask[b]`=1, `mem[waddr]` byte b takes `din` byte b; the other bytes keep their value. A mask of 0 is still an accepted write: the counter increments and the array is unchanged.
- **Read.** Accepted on a rising edge where `dmem_csb_read_i`=0. `mem[raddr]` is captured at that edge and launched into a READ_LATENCY-deep pipeline of data and valid bits. Stage 0 is loaded at the accepting edge.
- **Read/write collision.** A read and a write on the same edge to the same address return the OLD contents (read-first). The write still completes.
- Reads and writes are independent. Both may be accepted every cycle with no back-pressure.
- **Counters.** Each counter increments by 1 per accepted access and saturates at 2^CNT_W-1 with no wrap.
- **Array contents.** Not cleared by reset and undefined at power-up. Contents are retained across a reset assertion.
- **Reset** (`reset_i`=0, asynchronous):
  - `dmem_dout_o`=0, `rd_valid_o`=0, both counters=0.
  - All read-pipeline valid bits are cleared. A read in flight when reset asserts is dropped and produces no `rd_valid_o`.
  - Requests are ignored while reset is low.
- **Reset release.** Deassertion is synchronized by the system. The first request can be accepted on the first rising edge with `reset_i`=1.
- **Address range.** No out-of-range addresses exist; the address width exactly covers the array.
- **Unknown inputs.** X/Z on a select while out of reset is a protocol error. The bench flags it; the design behaviour is unspecified.

## Timing
- **Read latency.** For a read accepted at edge k, `dmem_dout_o` and `rd_valid_o`=1 appear after edge k+READ_LATENCY-1.
  - READ_LATENCY=1: the data is visible in the cycle immediately following edge k.
- **Read throughput.** One read per cycle. Back-to-back reads give consecutive `rd_valid_o` pulses and consecutive data.
- **Write-to-read.** A write at edge k is visible to a read accepted at edge k+1 or later. It is not visible to a read at edge k (read-first).
- **Data hold.** `dmem_dout_o` changes only with `rd_valid_o`=1 or on reset.
- **Counter timing.** Both counters update on the accepting edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Reset values.** Assert `reset_i`=0 mid-simulation with a READ_LATENCY=2 read in flight, then release → `dmem_dout_o`=0, `rd_valid_o` never pulses for the dropped read, counters=0.
- **Masked write.** Write 0xDEADBEEF to address 0x10 with mask 4'hF, then write 0x00AA0011 to 0x10 with mask 4'b0101, then read 0x10 → 0xDEAABE11 after READ_LATENCY edges, with a single `rd_valid_o` pulse.
- **Collision.** Hold 0x11111111 at address 0x20. On the same edge, write 0x22222222 (mask F) and read 0x20 → read returns 0x11111111. A read on the next edge returns 0x22222222.
- **Throughput and latency.** For READ_LATENCY in {1,2,3}, read addresses 0..7 on 8 consecutive edges after preloading mem[i]=i*3 → 8 consecutive `rd_valid_o` pulses with data 0,3,…,21, the first appearing after edge READ_LATENCY-1 relative to the first read; `rd_count_o`=8.
- **Saturation.** With CNT_W=4, issue 20 writes with mask 0 → `wr_count_o` stops at 15, array unchanged, `rd_count_o`=0.
- **Retention across reset.** Write 0xCAFEF00D to 0xFF, pulse reset, then read 0xFF → 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder that sits behind the core's dmem port. It stands in
// for the external SRAM macro in simulation and FPGA builds.
//
// Ports
//   clk_i             single clock, rising edge
//   reset_i           asynchronous active-low reset
//   dmem_csb_write_i  active-low write select
//   dmem_wmask_i      byte enables, bit b covers data bits [8b+7:8b]
//   dmem_waddr_i      write word address
//   dmem_din_i        write data
//   dmem_csb_read_i   active-low read select
//   dmem_raddr_i      read word address
//   dmem_dout_o       read data, held between reads
//   rd_valid_o        one-cycle strobe marking each dmem_dout_o update
//   wr_count_o        accepted writes, saturating
//   rd_count_o        accepted reads, saturating
//
// Read data enters a READ_LATENCY-deep pipeline at the accepting edge. The
// last stage drives the outputs directly, so every output is registered.
module dmem_responder #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  dmem_csb_write_i,
  input  logic [DATA_W/8-1:0]   dmem_wmask_i,
  input  logic [ADDR_W-1:0]     dmem_waddr_i,
  input  logic [DATA_W-1:0]     dmem_din_i,
  input  logic                  dmem_csb_read_i,
  input  logic [ADDR_W-1:0]     dmem_raddr_i,
  output logic [DATA_W-1:0]     dmem_dout_o,
  output logic                  rd_valid_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic [CNT_W-1:0]      rd_count_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0]       r_mem   [DEPTH];
  logic [DATA_W-1:0]       r_dat_p [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_vld_p;
  logic [CNT_W-1:0]        r_wr_cnt;
  logic [CNT_W-1:0]        r_rd_cnt;
  logic                    w_wr_acc;
  logic                    w_rd_acc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // The memory block has no reset, so it must gate writes on reset_i itself
  // to ignore requests while reset is held.
  assign w_wr_acc = reset_i & ~dmem_csb_write_i;
  assign w_rd_acc = reset_i & ~dmem_csb_read_i;

  // Array: contents survive reset and are never initialised.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (dmem_wmask_i[b]) begin
          r_mem[dmem_waddr_i][8*b +: 8] <= dmem_din_i[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline. Stage 0 samples the array with a non-blocking read, so a
  // same-edge write to the same address is not seen (read-first). Data stages
  // only advance behind a valid bit, which keeps the output holding between
  // reads.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_vld_p <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_dat_p[i] <= '0;
      end
    end else begin
      r_vld_p[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_dat_p[0] <= r_mem[dmem_raddr_i];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        if (r_vld_p[i-1]) begin
          r_dat_p[i] <= r_dat_p[i-1];
        end
      end
    end
  end

  // Access counters
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr_acc) r_wr_cnt <= sat_inc(r_wr_cnt);
      if (w_rd_acc) r_rd_cnt <= sat_inc(r_rd_cnt);
    end
  end

  assign dmem_dout_o = r_dat_p[READ_LATENCY-1];
  assign rd_valid_o  = r_vld_p[READ_LATENCY-1];
  assign wr_count_o  = r_wr_cnt;
  assign rd_count_o  = r_rd_cnt;

endmodule
